// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared types and constants for the serial adder/subtractor
// Purpose: FSM state encoding and operation select encoding used by serial_add_sub
//          and its bit cell.
// Contents: state_t (IDLE, RUN, DONE), OP_ADD, OP_SUB.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_sub_bit_cell.sv
// rtl/add_sub_bit_cell.sv - one-bit full adder / full subtractor cell
// Purpose: combinational bit slice for the serial datapath.
// Ports:
//   a, b  - operand bits
//   cin   - incoming carry (add) or borrow (subtract)
//   op    - OP_ADD or OP_SUB
//   s     - sum / difference bit
//   co    - outgoing carry (add) or borrow (subtract)
import serial_arith_pkg::*;

module add_sub_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic op,
  output logic s,
  output logic co
);

  logic carry;
  logic borrow;

  // Sum and difference bits are the same XOR; only the carry-out differs.
  assign s      = a ^ b ^ cin;
  assign carry  = (a & b) | (b & cin) | (cin & a);
  assign borrow = (~a & b) | (~a & cin) | (b & cin);
  assign co     = (op == OP_SUB) ? borrow : carry;

endmodule

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial unsigned adder/subtractor, LSB first
// Purpose: latches two WIDTH-bit operands on start and processes one bit per
//          clock, producing a registered result and final carry/borrow.
// Ports:
//   clk, rst_n - clock (rising edge), asynchronous active-low reset
//   start      - begin an operation (ignored while busy)
//   op         - 0 add, 1 subtract; sampled with start
//   a, b       - unsigned operands; sampled with start
//   busy       - high exactly while bits are being processed
//   done       - one-cycle pulse when result/cout are updated
//   result     - sum or difference, held until the next completion
//   cout       - final carry (add) or final borrow (subtract)
import serial_arith_pkg::*;

module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  // One extra bit so the counter can never wrap inside an operation.
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic             op_q;
  logic             c_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             bit_s;
  logic             bit_co;
  logic             last_bit;

  add_sub_bit_cell u_cell (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (c_q),
    .op  (op_q),
    .s   (bit_s),
    .co  (bit_co)
  );

  // New bit enters at the MSB; after WIDTH shifts bit 0 has reached the LSB.
  assign sum_d    = {bit_s, {(WIDTH-1){1'b0}}} | (sum_q >> 1);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= OP_ADD;
      c_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= bit_co;
          sum_q <= sum_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) begin
            result_q <= sum_d;
            cout_q   <= bit_co;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 The block SHALL have the port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have the port start, input, 1 bit: request a new operation; sampled on clk rise.
REQ-005 The block SHALL have the port op, input, 1 bit: 0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-006 The block SHALL have the port a, input, WIDTH bits: operand A, unsigned; sampled with start.
REQ-007 The block SHALL have the port b, input, WIDTH bits: operand B, unsigned; sampled with start.
REQ-008 The block SHALL have the port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have the port done, output, 1 bit: single-cycle pulse marking that result and cout are valid.
REQ-010 The block SHALL have the port result, output, WIDTH bits: sum or difference, registered.
REQ-011 The block SHALL have the port cout, output, 1 bit: final carry (add) or final borrow (subtract), registered.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE; its reset state SHALL be IDLE.
REQ-013 In IDLE or DONE, start=1 SHALL latch a, b and op into shift registers, clear the carry/borrow flop and bit counter, and move the FSM to RUN.
REQ-014 In RUN, start SHALL be ignored; the operand registers SHALL NOT change.
REQ-015 Each RUN cycle SHALL process one bit, LSB first: bit cell inputs are A[0], B[0] and the cin/bin flop; outputs shift into result MSB-side; A and B shift right.
REQ-016 Add bit SHALL be s = a^b^c, co = ab|bc|ca.
REQ-017 Subtract bit SHALL be d = a^b^c, bo = (~a&b)|(~a&c)|(b&c).
REQ-018 After exactly WIDTH RUN cycles, the FSM SHALL enter DONE, drive done=1 for one cycle, drive busy=0, and present the final carry/borrow on cout.
REQ-019 Latency: the start edge plus WIDTH clocks SHALL elapse to the edge at which done is observed high; throughput SHALL be one operation per WIDTH+1 cycles, with back-to-back start permitted in DONE.
REQ-020 In DONE without start, the FSM SHALL return to IDLE next cycle; result and cout SHALL hold until the next operation completes.
REQ-021 busy SHALL be 1 exactly while in RUN.
REQ-022 Subtract with a<b SHALL give result = (a-b) mod 2^WIDTH and cout=1; with a>=b it SHALL give cout=0.
REQ-023 Add overflow SHALL give result = (a+b) mod 2^WIDTH and cout=1.
REQ-024 The bit counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap within one operation.

Reset
REQ-025 rst_n low SHALL, asynchronously, force state=IDLE, busy=0, done=0, result=0, cout=0, and clear the counter, carry flop and operand registers.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release the block SHALL accept start normally.

Structure
REQ-027 Package serial_arith_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the op encoding constants OP_ADD=0 and OP_SUB=1.
REQ-028 One sub-module, add_sub_bit_cell, SHALL implement the combinational bit cell: inputs a, b, cin, op; outputs s, co.
REQ-029 The carry/borrow flop, shift registers, counter and FSM SHALL reside in serial_add_sub.

Verification (WIDTH=8)
REQ-030 Add: a=8'h35, b=8'h4A, op=0 -> done after 8 clocks, result=8'h7F, cout=0.
REQ-031 Add overflow: a=8'hFF, b=8'h01 -> result=8'h00, cout=1.
REQ-032 Subtract: a=8'h10, b=8'h01 -> result=8'h0F, cout=0; a=8'h00, b=8'h01 -> result=8'hFF, cout=1.
REQ-033 start pulsed at RUN cycle 3 with different operands -> ignored; the original result is delivered and busy stays high for 8 cycles.
REQ-034 rst_n low at RUN cycle 4 -> busy, done, result, cout =0 immediately; no done pulse; a fresh add 8'h01+8'h01 after release gives 8'h02.
REQ-035 start held high through DONE -> a second operation begins with no IDLE cycle; two done pulses are spaced 9 cycles apart.
